// File: rtl/varredura_pkg.sv
// varredura_pkg: shared states, sizes and helpers for the LED matrix scan driver.
package varredura_pkg;

  localparam int NUM_LINHAS  = 7;
  localparam int NUM_COLUNAS = 5;
  localparam int NUM_QUADROS = 8;

  typedef enum logic [1:0] {
    APAGAR,
    CARREGAR,
    EXIBIR
  } estado_t;

  // Counter width for a modulo-n count, never narrower than one bit.
  function automatic int larg(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/varredura_contador_modulo.sv
// contador_modulo: modulo-N up counter with enable, clear and terminal count.
module contador_modulo #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o,
  output logic         tc_o
);

  localparam logic [W-1:0] ULTIMO = W'(N - 1);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  assign tc_o = (q_q == ULTIMO);
  assign q_o  = q_q;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = tc_o ? '0 : q_q + W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/varredura_matriz.sv
// varredura_matriz: 7x5 LED matrix row scanner with blanking and frame stepping.
// Define VARREDURA_ATIVO_BAIXO_EN for active-low row/column drive.
module varredura_matriz
  import varredura_pkg::*;
#(
  parameter int DIV_LINHA         = 50000,
  parameter int BLANK_CICLOS      = 4,
  parameter int QUADRO_VARREDURAS = 500
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   habilita,
  input  logic                   modo_auto,
  input  logic                   avancar,
  input  logic [NUM_COLUNAS-1:0] colunas_in,
  output logic [2:0]             quadros,
  output logic [2:0]             contador,
  output logic [NUM_LINHAS-1:0]  linhas,
  output logic [NUM_COLUNAS-1:0] colunas_out,
  output logic                   fim_quadro
);

`ifdef VARREDURA_ATIVO_BAIXO_EN
  localparam logic ATIVO_BAIXO = 1'b1;
`else
  localparam logic ATIVO_BAIXO = 1'b0;
`endif

  localparam logic [NUM_LINHAS-1:0]  LIN_OFF = {NUM_LINHAS{ATIVO_BAIXO}};
  localparam logic [NUM_COLUNAS-1:0] COL_OFF = {NUM_COLUNAS{ATIVO_BAIXO}};

  localparam int TMAX =
    (DIV_LINHA > BLANK_CICLOS) ? DIV_LINHA : BLANK_CICLOS;
  localparam int TW = larg(TMAX);
  localparam int SW = larg(QUADRO_VARREDURAS);

  localparam logic [TW-1:0] T_BLANK = TW'(BLANK_CICLOS - 1);
  localparam logic [TW-1:0] T_DIV   = TW'(DIV_LINHA - 1);

  estado_t estado_q, estado_d;

  logic [NUM_LINHAS-1:0]  linhas_q, linhas_d;
  logic [NUM_COLUNAS-1:0] colunas_q, colunas_d;
  logic [2:0]             quadros_q, quadros_d;
  logic                   fim_q, fim_d;
  logic                   pend_q, pend_d;

  logic [TW-1:0] t_q;
  logic          t_clr;
  logic          unused_t_tc;
  logic [2:0]    linha_q;
  logic          linha_tc;
  logic          linha_en;
  logic          linha_clr;
  logic [SW-1:0] unused_scan_q;
  logic          scan_tc;
  logic          scan_en;
  logic          scan_clr;
  logic          fim_timer;
  logic          avanca;

  contador_modulo #(.N(TMAX), .W(TW)) u_timer (
    .clock_i (clock),
    .reset_i (reset),
    .clr_i   (t_clr),
    .en_i    (1'b1),
    .q_o     (t_q),
    .tc_o    (unused_t_tc)
  );

  contador_modulo #(.N(NUM_LINHAS), .W(3)) u_linha (
    .clock_i (clock),
    .reset_i (reset),
    .clr_i   (linha_clr),
    .en_i    (linha_en),
    .q_o     (linha_q),
    .tc_o    (linha_tc)
  );

  contador_modulo #(.N(QUADRO_VARREDURAS), .W(SW)) u_scan (
    .clock_i (clock),
    .reset_i (reset),
    .clr_i   (scan_clr),
    .en_i    (scan_en),
    .q_o     (unused_scan_q),
    .tc_o    (scan_tc)
  );

  always_comb begin
    estado_d  = estado_q;
    linhas_d  = linhas_q;
    colunas_d = colunas_q;
    quadros_d = quadros_q;
    fim_d     = 1'b0;
    pend_d    = pend_q | avancar;
    fim_timer = 1'b0;
    avanca    = 1'b0;
    t_clr     = 1'b0;
    linha_en  = 1'b0;
    linha_clr = 1'b0;
    scan_en   = 1'b0;
    scan_clr  = 1'b0;
    if (!habilita) begin
      estado_d  = APAGAR;
      linhas_d  = LIN_OFF;
      colunas_d = COL_OFF;
      t_clr     = 1'b1;
      linha_clr = 1'b1;
    end else begin
      unique case (estado_q)
        APAGAR: begin
          fim_timer = (t_q == T_BLANK);
          t_clr     = fim_timer;
          if (fim_timer) estado_d = CARREGAR;
        end
        CARREGAR: begin
          t_clr     = 1'b1;
          colunas_d = colunas_in ^ COL_OFF;
          linhas_d  = (NUM_LINHAS'(1) << linha_q) ^ LIN_OFF;
          estado_d  = EXIBIR;
        end
        EXIBIR: begin
          fim_timer = (t_q == T_DIV);
          t_clr     = fim_timer;
          if (fim_timer) begin
            estado_d = APAGAR;
            linhas_d = LIN_OFF;
            linha_en = 1'b1;
            if (linha_tc) begin
              // Frames only change on a row wrap so a frame never tears.
              avanca   = (modo_auto & scan_tc) | pend_q;
              scan_en  = ~avanca;
              scan_clr = avanca;
              if (avanca) begin
                quadros_d = quadros_q + 3'd1;
                fim_d     = 1'b1;
                pend_d    = avancar;
              end
            end
          end
        end
        default: estado_d = APAGAR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= APAGAR;
      linhas_q  <= LIN_OFF;
      colunas_q <= COL_OFF;
      quadros_q <= '0;
      fim_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      linhas_q  <= linhas_d;
      colunas_q <= colunas_d;
      quadros_q <= quadros_d;
      fim_q     <= fim_d;
      pend_q    <= pend_d;
    end
  end

  assign quadros     = quadros_q;
  assign contador    = linha_q;
  assign linhas      = linhas_q;
  assign colunas_out = colunas_q;
  assign fim_quadro  = fim_q;

endmodule
